// File: rtl/crypto_pkg.sv
// Shared constants and types for the crypto_switch classifier path:
// header field offsets in AXI lane order, mark bit default and FSM state encoding.
package crypto_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0008;
  localparam logic [3:0]  IPV4_VERSION   = 4'd4;

  localparam int ETH_TYPE_LSB = 96;
  localparam int IP_VER_LSB   = 116;
  localparam int IP_PROTO_LSB = 184;

  // Bytes 0..23 must all be present for the protocol field to be trusted.
  localparam int HDR_BYTES = 24;

  localparam int MARK_BIT_DEFAULT = 32;

  typedef enum logic {
    SOP = 1'b0,
    MID = 1'b1
  } pkt_state_t;

endpackage

// File: rtl/crypto_axis_reg_slice.sv
// Generic 1-deep AXI-Stream register slice; selected tuser bits are replaced
// by an override value as the beat is loaded.
module crypto_axis_reg_slice #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128
) (
  input  logic                axis_aclk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic [DATA_W/8-1:0] s_tkeep,
  input  logic [USER_W-1:0]   s_tuser,
  input  logic                s_tlast,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic [USER_W-1:0]   tuser_ovr_mask,
  input  logic [USER_W-1:0]   tuser_ovr_val,
  output logic [DATA_W-1:0]   m_tdata,
  output logic [DATA_W/8-1:0] m_tkeep,
  output logic [USER_W-1:0]   m_tuser,
  output logic                m_tlast,
  output logic                m_tvalid,
  input  logic                m_tready
);

  // Accept whenever the register is empty or being drained this cycle.
  assign s_tready = !m_tvalid || m_tready;

  // NOTE: non-blocking assignments keep every register sampling pre-edge values,
  // so the order of statements inside the block cannot change behaviour.
  // NOTE: the payload registers are reset because downstream sees them as
  // defined zeros after reset; a wider pipeline would normally leave data unreset.
  always_ff @(posedge axis_aclk or posedge reset) begin
    if (reset) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tuser  <= '0;
      m_tlast  <= 1'b0;
    end else if (s_tvalid && s_tready) begin
      m_tvalid <= 1'b1;
      m_tdata  <= s_tdata;
      m_tkeep  <= s_tkeep;
      m_tuser  <= (s_tuser & ~tuser_ovr_mask) | (tuser_ovr_val & tuser_ovr_mask);
      m_tlast  <= s_tlast;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/crypto_pkt_classifier.sv
// Classifies each packet from its first beat (Ethernet + IPv4 header) and stamps
// an encrypt-eligible mark into tuser for every beat; keeps per-class counters.
module crypto_pkt_classifier
  import crypto_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int MARK_BIT           = MARK_BIT_DEFAULT,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                             axis_aclk,
  input  logic                             reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  input  logic [7:0]                       cfg_ip_proto,
  input  logic                             cfg_enable,
  input  logic                             cnt_clear,
  output logic [CNT_WIDTH-1:0]             match_cnt,
  output logic [CNT_WIDTH-1:0]             pass_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [C_AXIS_TUSER_WIDTH-1:0] MARK_MASK =
    {{(C_AXIS_TUSER_WIDTH-1){1'b0}}, 1'b1} << MARK_BIT;

  pkt_state_t state;
  logic       pkt_mark;
  logic       match;
  logic       mark;
  logic       s_fire;
  logic       sop_fire;

  assign s_fire   = s_axis_tvalid && s_axis_tready;
  assign sop_fire = s_fire && (state == SOP);

  assign match = cfg_enable
              && (s_axis_tdata[ETH_TYPE_LSB +: 16] == ETHERTYPE_IPV4)
              && (s_axis_tdata[IP_VER_LSB +: 4]    == IPV4_VERSION)
              && (s_axis_tdata[IP_PROTO_LSB +: 8]  == cfg_ip_proto)
              && (&s_axis_tkeep[HDR_BYTES-1:0]);

  // NOTE: the default assignment first guarantees mark is driven on every path,
  // so no latch is inferred if the state test is ever extended.
  always_comb begin
    mark = pkt_mark;
    if (state == SOP) mark = match;
  end

  always_ff @(posedge axis_aclk or posedge reset) begin
    if (reset) begin
      state    <= SOP;
      pkt_mark <= 1'b0;
    end else if (s_fire) begin
      case (state)
        SOP: begin
          pkt_mark <= match;
          state    <= s_axis_tlast ? SOP : MID;
        end
        MID: if (s_axis_tlast) state <= SOP;
        default: state <= SOP;
      endcase
    end
  end

  // Saturating counters; a clear wins over a coincident increment.
  always_ff @(posedge axis_aclk or posedge reset) begin
    if (reset) begin
      match_cnt <= '0;
      pass_cnt  <= '0;
    end else if (cnt_clear) begin
      match_cnt <= '0;
      pass_cnt  <= '0;
    end else if (sop_fire) begin
      if (match && (match_cnt != CNT_MAX)) match_cnt <= match_cnt + CNT_WIDTH'(1);
      if (!match && (pass_cnt != CNT_MAX)) pass_cnt  <= pass_cnt + CNT_WIDTH'(1);
    end
  end

  crypto_axis_reg_slice #(
    .DATA_W (C_AXIS_DATA_WIDTH),
    .USER_W (C_AXIS_TUSER_WIDTH)
  ) u_slice (
    .axis_aclk      (axis_aclk),
    .reset          (reset),
    .s_tdata        (s_axis_tdata),
    .s_tkeep        (s_axis_tkeep),
    .s_tuser        (s_axis_tuser),
    .s_tlast        (s_axis_tlast),
    .s_tvalid       (s_axis_tvalid),
    .s_tready       (s_axis_tready),
    .tuser_ovr_mask (MARK_MASK),
    .tuser_ovr_val  (mark ? MARK_MASK : '0),
    .m_tdata        (m_axis_tdata),
    .m_tkeep        (m_axis_tkeep),
    .m_tuser        (m_axis_tuser),
    .m_tlast        (m_axis_tlast),
    .m_tvalid       (m_axis_tvalid),
    .m_tready       (m_axis_tready)
  );

endmodule

// File: tb/tb_crypto_pkt_classifier.sv
// Bench for crypto_pkt_classifier: directed scenarios plus randomized packets
// checked against a packet-level reference model and expected-beat queue.
module tb_crypto_pkt_classifier;

  localparam int CW       = 4;
  localparam int MARK     = 32;
  localparam int CNT_MAXV = (1 << CW) - 1;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic [127:0] user;
    logic         last;
  } beat_t;

  logic           axis_aclk = 1'b0;
  logic           reset;
  logic [255:0]   s_axis_tdata  = '0;
  logic [31:0]    s_axis_tkeep  = '0;
  logic [127:0]   s_axis_tuser  = '0;
  logic           s_axis_tvalid = 1'b0;
  logic           s_axis_tready;
  logic           s_axis_tlast  = 1'b0;
  logic [255:0]   m_axis_tdata;
  logic [31:0]    m_axis_tkeep;
  logic [127:0]   m_axis_tuser;
  logic           m_axis_tvalid;
  logic           m_axis_tready = 1'b1;
  logic           m_axis_tlast;
  logic [7:0]     cfg_ip_proto  = 8'd17;
  logic           cfg_enable    = 1'b1;
  logic           cnt_clear     = 1'b0;
  logic [CW-1:0]  match_cnt;
  logic [CW-1:0]  pass_cnt;

  crypto_pkt_classifier #(
    .C_AXIS_DATA_WIDTH  (256),
    .C_AXIS_TUSER_WIDTH (128),
    .MARK_BIT           (MARK),
    .CNT_WIDTH          (CW)
  ) dut (
    .axis_aclk     (axis_aclk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .cfg_ip_proto  (cfg_ip_proto),
    .cfg_enable    (cfg_enable),
    .cnt_clear     (cnt_clear),
    .match_cnt     (match_cnt),
    .pass_cnt      (pass_cnt)
  );

  always #5 axis_aclk = ~axis_aclk;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cycles  = 0;
  beat_t exp_q[$];
  bit    ready_seq[$];
  bit    rnd_ready = 0;
  bit    in_pkt    = 0;
  bit    cur_mark  = 0;
  int    ref_match_cnt = 0;
  int    ref_pass_cnt  = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Header rules read byte by byte, as a packet parser would see them.
  function automatic bit ref_classify(input logic [255:0] d, input logic [31:0] k,
                                      input logic [7:0] proto, input logic en);
    logic [7:0] b [32];
    bit full;
    for (int n = 0; n < 32; n++) b[n] = d[8*n +: 8];
    full = 1;
    for (int n = 0; n < 24; n++) if (k[n] !== 1'b1) full = 0;
    return (en === 1'b1) && (b[12] == 8'h08) && (b[13] == 8'h00) &&
           (b[14][7:4] == 4'h4) && (b[23] == proto) && full;
  endfunction

  function automatic logic [255:0] rand_data();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [255:0] make_first(input logic [15:0] etype, input logic [3:0] ver,
                                              input logic [7:0] proto);
    logic [255:0] d;
    d = rand_data();
    d[111:96]  = etype;
    d[119:116] = ver;
    d[191:184] = proto;
    return d;
  endfunction

  // One clock: check outputs against the model, then advance the model across the edge.
  task automatic tick(output bit acc);
    beat_t exp_b;
    beat_t nb;
    bit    ev;
    bit    m;
    bit    sop;
    @(negedge axis_aclk);
    ev = (exp_q.size() != 0);
    chk("m_tvalid", 256'(m_axis_tvalid), 256'(ev));
    if (ev) begin
      exp_b = exp_q[0];
      chk("m_tdata", m_axis_tdata, exp_b.data);
      chk("m_tkeep", 256'(m_axis_tkeep), 256'(exp_b.keep));
      chk("m_tuser", 256'(m_axis_tuser), 256'(exp_b.user));
      chk("m_tlast", 256'(m_axis_tlast), 256'(exp_b.last));
    end
    chk("s_tready", 256'(s_axis_tready), 256'(!ev || m_axis_tready));
    chk("match_cnt", 256'(match_cnt), 256'(ref_match_cnt));
    chk("pass_cnt", 256'(pass_cnt), 256'(ref_pass_cnt));
    acc = s_axis_tvalid && (!ev || m_axis_tready);
    sop = 0;
    m   = 0;
    if (ev && m_axis_tready) void'(exp_q.pop_front());
    if (acc) begin
      if (!in_pkt) begin
        m        = ref_classify(s_axis_tdata, s_axis_tkeep, cfg_ip_proto, cfg_enable);
        cur_mark = m;
        sop      = 1;
      end else begin
        m = cur_mark;
      end
      in_pkt  = !s_axis_tlast;
      nb.data = s_axis_tdata;
      nb.keep = s_axis_tkeep;
      nb.user = s_axis_tuser;
      nb.user[MARK] = m;
      nb.last = s_axis_tlast;
      exp_q.push_back(nb);
    end
    if (cnt_clear) begin
      ref_match_cnt = 0;
      ref_pass_cnt  = 0;
    end else if (sop) begin
      if (m && ref_match_cnt < CNT_MAXV) ref_match_cnt++;
      if (!m && ref_pass_cnt < CNT_MAXV) ref_pass_cnt++;
    end
    @(posedge axis_aclk);
    #1;
    cycles++;
    if (ready_seq.size() != 0) m_axis_tready = ready_seq.pop_front();
    else if (rnd_ready) m_axis_tready = ($urandom_range(0, 3) != 0);
    if (cycles > 60000) begin
      n_tests++;
      n_fail++;
      $display("FAIL cycle_budget: observed %0d cycles, required under 60000", cycles);
      $fatal(1);
    end
  endtask

  task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic l,
                           input int idle);
    bit acc;
    int n;
    if (idle > 0) begin
      s_axis_tvalid = 1'b0;
      repeat (idle) tick(acc);
    end
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = {$urandom, $urandom, $urandom, $urandom};
    s_axis_tvalid = 1'b1;
    n   = 0;
    acc = 0;
    while (!acc && n < 200) begin
      tick(acc);
      n++;
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: observed no accept in %0d cycles, required accept", n);
      $fatal(1);
    end
  endtask

  task automatic send_pkt(input logic [15:0] etype, input logic [3:0] ver, input logic [7:0] proto,
                          input int nbeats, input logic [31:0] keep0, input int idle,
                          input bit clr, input bit cfg_wiggle);
    for (int i = 0; i < nbeats; i++) begin
      cnt_clear = clr && (i == 0);
      send_beat((i == 0) ? make_first(etype, ver, proto) : rand_data(),
                (i == 0) ? keep0 : 32'hFFFF_FFFF, (i == nbeats - 1), (i == 0) ? idle : 0);
      cnt_clear = 1'b0;
      if (cfg_wiggle && i == 0) begin
        cfg_ip_proto = 8'($urandom);
        cfg_enable   = 1'($urandom);
      end
    end
  endtask

  task automatic drain();
    bit acc;
    int n;
    s_axis_tvalid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick(acc);
      n++;
    end
    chk("drain", 256'(exp_q.size()), 256'(0));
    tick(acc);
  endtask

  task automatic do_reset();
    s_axis_tvalid = 1'b0;
    cnt_clear     = 1'b0;
    reset         = 1'b1;
    #1;
    chk("rst_tvalid", 256'(m_axis_tvalid), 256'(0));
    chk("rst_tdata", m_axis_tdata, 256'(0));
    chk("rst_tuser", 256'(m_axis_tuser), 256'(0));
    chk("rst_tkeep_tlast", 256'({m_axis_tkeep, m_axis_tlast}), 256'(0));
    chk("rst_counters", 256'({match_cnt, pass_cnt}), 256'(0));
    exp_q.delete();
    in_pkt        = 0;
    cur_mark      = 0;
    ref_match_cnt = 0;
    ref_pass_cnt  = 0;
    @(posedge axis_aclk);
    #1;
    @(posedge axis_aclk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    #2;
    do_reset();

    // 3-beat UDP packet, ready held high.
    cfg_ip_proto = 8'd17;
    cfg_enable   = 1'b1;
    send_pkt(16'h0008, 4'h4, 8'd17, 3, 32'hFFFF_FFFF, 1, 0, 0);
    drain();
    chk("udp3_match_cnt", 256'(match_cnt), 256'(1));
    chk("udp3_pass_cnt", 256'(pass_cnt), 256'(0));

    // 2-beat ARP packet.
    send_pkt(16'h0608, 4'h4, 8'd17, 2, 32'hFFFF_FFFF, 1, 0, 0);
    drain();
    chk("arp_pass_cnt", 256'(pass_cnt), 256'(1));

    // Back-to-back single-beat UDP then TCP with tvalid held.
    send_pkt(16'h0008, 4'h4, 8'd17, 1, 32'hFFFF_FFFF, 0, 0, 0);
    send_pkt(16'h0008, 4'h4, 8'd6, 1, 32'hFFFF_FFFF, 0, 0, 0);
    drain();
    chk("b2b_counts", 256'({match_cnt, pass_cnt}), 256'({4'd2, 4'd2}));

    // 4-beat UDP with downstream stalls.
    ready_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    send_pkt(16'h0008, 4'h4, 8'd17, 4, 32'hFFFF_FFFF, 1, 0, 0);
    drain();
    chk("stall_match_cnt", 256'(match_cnt), 256'(3));

    // Truncated first beat: byte 23 absent.
    send_pkt(16'h0008, 4'h4, 8'd17, 1, 32'h000F_FFFF, 1, 0, 0);
    drain();
    chk("trunc_pass_cnt", 256'(pass_cnt), 256'(3));

    // Counter saturation and clear priority.
    do_reset();
    for (int i = 0; i < CNT_MAXV + 1; i++)
      send_pkt(16'h0008, 4'h4, 8'd17, 1, 32'hFFFF_FFFF, 0, 0, 0);
    drain();
    chk("sat_match_cnt", 256'(match_cnt), 256'(CNT_MAXV));
    send_pkt(16'h0008, 4'h4, 8'd17, 1, 32'hFFFF_FFFF, 1, 1, 0);
    drain();
    chk("clear_match_cnt", 256'(match_cnt), 256'(0));

    // Reset in the middle of a non-matching packet; next beat must be a fresh SOP.
    send_beat(make_first(16'h0608, 4'h4, 8'd17), 32'hFFFF_FFFF, 1'b0, 1);
    send_beat(rand_data(), 32'hFFFF_FFFF, 1'b0, 0);
    do_reset();
    send_pkt(16'h0008, 4'h4, 8'd17, 1, 32'hFFFF_FFFF, 1, 0, 0);
    drain();
    chk("post_rst_sop_match", 256'(match_cnt), 256'(1));

    // Randomized traffic with random backpressure and mid-packet config changes.
    rnd_ready = 1;
    for (int p = 0; p < 80; p++) begin
      logic [15:0] et;
      logic [3:0]  vr;
      logic [7:0]  pr;
      logic [31:0] k0;
      cfg_enable   = ($urandom_range(0, 7) != 0);
      cfg_ip_proto = $urandom_range(0, 1) ? 8'd17 : 8'd6;
      et = ($urandom_range(0, 9) == 0) ? 16'h0608 : 16'h0008;
      vr = ($urandom_range(0, 9) == 0) ? 4'h6 : 4'h4;
      pr = $urandom_range(0, 1) ? cfg_ip_proto : ($urandom_range(0, 1) ? 8'd6 : 8'd1);
      k0 = ($urandom_range(0, 7) == 0) ? 32'h007F_FFFF : 32'hFFFF_FFFF;
      send_pkt(et, vr, pr, $urandom_range(1, 4), k0, $urandom_range(0, 2),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));
    end
    rnd_ready     = 0;
    m_axis_tready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
